vend_sequencer: RTL and testbench

- Sits downstream of the newspaper pricing FSM.
- Turns its per-cycle vend/change strobes (R, N1, D1, D2) into timed actuator commands:
  - one paper-latch release pulse;
  - one coin-eject pulse per change coin (nickels first, then dimes), each confirmed by a dispenser coin-sensed acknowledge.
- Inhibits the coin acceptor while a vend is in progress and latches a fault on dispenser timeout.

---
 rtl/vend_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_vend_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: turns the pricing FSM's vend/change strobes into timed
// latch-release and coin-eject pulses, waits for a dispenser acknowledge on
// each coin, and latches a fault when the dispenser does not respond.
module vend_sequencer #(
    parameter int unsigned PULSE_W     = 4,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned GAP         = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vend_r,
    input  logic chg_n1,
    input  logic chg_d1,
    input  logic chg_d2,
    input  logic coin_ack,
    input  logic fault_clr,
    output logic latch_out,
    output logic nickel_eject,
    output logic dime_eject,
    output logic coin_inhibit,
    output logic busy,
    output logic vend_done,
    output logic fault,
    output logic overrun
);

    typedef enum logic [2:0] {
        StIdle, StLatch, StGap, StDispN, StDispD, StWaitAck, StDone, StFault
    } state_e;

    localparam logic [7:0] PulseLast = 8'(PULSE_W - 1);
    localparam logic [7:0] GapLast   = 8'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [7:0] AckLast   = 8'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    state_e      tgt_q, tgt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        n_cnt_q, n_cnt_d;
    logic [1:0]  d_cnt_q, d_cnt_d;
    logic        dime_q, dime_d;
    logic        overrun_d;
    logic        go;
    state_e      go_tgt;

    // Nickels are always paid out before dimes.
    function automatic state_e pick_next(input logic n, input logic [1:0] d);
        if (n) begin
            return StDispN;
        end else if (d != 2'd0) begin
            return StDispD;
        end
        return StDone;
    endfunction

    // Next-state, counter and pending-change bookkeeping.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        n_cnt_d   = n_cnt_q;
        d_cnt_d   = d_cnt_q;
        dime_d    = dime_q;
        go        = 1'b0;
        go_tgt    = StDone;
        overrun_d = (overrun & ~fault_clr) | (vend_r & (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (vend_r) begin
                    n_cnt_d = chg_n1;
                    d_cnt_d = chg_d2 ? 2'd2 : (chg_d1 ? 2'd1 : 2'd0);
                    cnt_d   = 8'd0;
                    state_d = StLatch;
                end
            end
            StLatch: begin
                if (cnt_q == PulseLast) begin
                    cnt_d  = 8'd0;
                    go     = 1'b1;
                    go_tgt = pick_next(n_cnt_q, d_cnt_q);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = 8'd0;
                    state_d = tgt_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDispN, StDispD: begin
                if (cnt_q == PulseLast) begin
                    cnt_d   = 8'd0;
                    dime_d  = (state_q == StDispD);
                    state_d = StWaitAck;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWaitAck: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (coin_ack) begin
                    cnt_d = 8'd0;
                    go    = 1'b1;
                    if (dime_q) begin
                        d_cnt_d = d_cnt_q - 2'd1;
                        go_tgt  = pick_next(n_cnt_q, d_cnt_q - 2'd1);
                    end else begin
                        n_cnt_d = 1'b0;
                        go_tgt  = pick_next(1'b0, d_cnt_q);
                    end
                end else if (cnt_q == AckLast) begin
                    cnt_d   = 8'd0;
                    state_d = StFault;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StFault: begin
                if (fault_clr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Leaving a pulse/ack phase: insert the idle gap unless it is zero.
        if (go) begin
            if (GAP == 0) begin
                state_d = go_tgt;
            end else begin
                state_d = StGap;
                tgt_d   = go_tgt;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tgt_q   <= StIdle;
            cnt_q   <= 8'd0;
            n_cnt_q <= 1'b0;
            d_cnt_q <= 2'd0;
            dime_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            n_cnt_q <= n_cnt_d;
            d_cnt_q <= d_cnt_d;
            dime_q  <= dime_d;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_out    <= 1'b0;
            nickel_eject <= 1'b0;
            dime_eject   <= 1'b0;
            coin_inhibit <= 1'b0;
            busy         <= 1'b0;
            vend_done    <= 1'b0;
            fault        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            latch_out    <= (state_d == StLatch);
            nickel_eject <= (state_d == StDispN);
            dime_eject   <= (state_d == StDispD);
            coin_inhibit <= (state_d != StIdle);
            busy         <= (state_d != StIdle) && (state_d != StFault);
            vend_done    <= (state_d == StDone);
            fault        <= (state_d == StFault);
            overrun      <= overrun_d;
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed scenarios; expected output edges are queued when
// stimulus is planned and a negedge monitor pops and compares each edge seen.
module tb_vend_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic vend_r, chg_n1, chg_d1, chg_d2, coin_ack, fault_clr;
    logic latch_out, nickel_eject, dime_eject, coin_inhibit, busy;
    logic vend_done, fault, overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    string sig_name [5] = '{"latch", "nickel", "dime", "done", "fault"};
    logic [4:0] prev = 5'b0;

    vend_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vend_r       (vend_r),
        .chg_n1       (chg_n1),
        .chg_d1       (chg_d1),
        .chg_d2       (chg_d2),
        .coin_ack     (coin_ack),
        .fault_clr    (fault_clr),
        .latch_out    (latch_out),
        .nickel_eject (nickel_eject),
        .dime_eject   (dime_eject),
        .coin_inhibit (coin_inhibit),
        .busy         (busy),
        .vend_done    (vend_done),
        .fault        (fault),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        return {sig_name[k / 2], (k % 2) ? "_fall" : "_rise"};
    endfunction

    task automatic see_edge(input int k);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL edge: got %s@%0d want none", ev_name(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                bad++;
                $display("FAIL edge: got %s@%0d want %s@%0d",
                         ev_name(k), cyc, ev_name(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: every rise/fall of a pulse output must match the queue head.
    always @(negedge clk) begin : mon
        logic [4:0] cur;
        cur = {fault, vend_done, dime_eject, nickel_eject, latch_out};
        for (int i = 0; i < 5; i++) begin
            if (cur[i] !== prev[i]) see_edge(i * 2 + (cur[i] ? 0 : 1));
        end
        prev = cur;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_pulse(input int sig, input int start, input int width);
        exp_q.push_back('{kind: sig * 2, cyc: start});
        exp_q.push_back('{kind: sig * 2 + 1, cyc: start + width});
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sample(input int c);
        goto(c);
        @(negedge clk);
    endtask

    task automatic vend(input int b, input logic n1, input logic d1, input logic d2);
        goto(b);
        vend_r = 1'b1; chg_n1 = n1; chg_d1 = d1; chg_d2 = d2;
        goto(b + 1);
        vend_r = 1'b0; chg_n1 = 1'b0; chg_d1 = 1'b0; chg_d2 = 1'b0;
    endtask

    task automatic ack_at(input int c);
        goto(c);
        coin_ack = 1'b1;
        goto(c + 1);
        coin_ack = 1'b0;
    endtask

    initial begin
        int b;
        rst_n = 1'b0; vend_r = 1'b0; chg_n1 = 1'b0; chg_d1 = 1'b0; chg_d2 = 1'b0;
        coin_ack = 1'b0; fault_clr = 1'b0;

        // Reset state.
        sample(2);
        check("rst_latch", latch_out, 0);
        check("rst_nickel", nickel_eject, 0);
        check("rst_dime", dime_eject, 0);
        check("rst_inhibit", coin_inhibit, 0);
        check("rst_busy", busy, 0);
        check("rst_done", vend_done, 0);
        check("rst_fault", fault, 0);
        check("rst_overrun", overrun, 0);
        goto(3);
        rst_n = 1'b1;

        // 1: no change; stray chg_n1 without vend_r beforehand is ignored.
        b = cyc + 3;
        exp_pulse(0, b + 1, 4);
        exp_pulse(3, b + 7, 1);
        goto(b - 1);
        chg_n1 = 1'b1;
        vend(b, 0, 0, 0);
        sample(b + 2);
        check("s1_inhibit", coin_inhibit, 1);
        sample(b + 7);
        check("s1_busy_done", busy, 1);
        sample(b + 8);
        check("s1_busy_end", busy, 0);
        check("s1_inhibit_end", coin_inhibit, 0);

        // 2: nickel + dime, acks 3 cycles after each eject falls.
        b = cyc + 3;
        exp_pulse(0, b + 1, 4);
        exp_pulse(1, b + 7, 4);
        exp_pulse(2, b + 17, 4);
        exp_pulse(3, b + 27, 1);
        vend(b, 1, 1, 0);
        ack_at(b + 14);
        ack_at(b + 24);
        goto(b + 30);

        // 6: as 2, plus spurious acks during latch and dime pulses.
        b = cyc + 3;
        exp_pulse(0, b + 1, 4);
        exp_pulse(1, b + 7, 4);
        exp_pulse(2, b + 17, 4);
        exp_pulse(3, b + 27, 1);
        vend(b, 1, 1, 0);
        ack_at(b + 2);
        ack_at(b + 14);
        ack_at(b + 18);
        ack_at(b + 24);
        goto(b + 30);

        // 7: all change lines (d2 wins over d1); ack on the last timeout cycle.
        b = cyc + 3;
        exp_pulse(0, b + 1, 4);
        exp_pulse(1, b + 7, 4);
        exp_pulse(2, b + 29, 4);
        exp_pulse(2, b + 36, 4);
        exp_pulse(3, b + 44, 1);
        vend(b, 1, 1, 1);
        sample(b + 26);
        check("s7_fault_boundary", fault, 0);
        ack_at(b + 26);
        ack_at(b + 33);
        ack_at(b + 41);
        goto(b + 47);

        // 3: two dimes, second never acked -> fault; vend in fault is dropped.
        b = cyc + 3;
        exp_pulse(0, b + 1, 4);
        exp_pulse(2, b + 7, 4);
        exp_pulse(2, b + 17, 4);
        exp_pulse(4, b + 37, 4);
        vend(b, 0, 0, 1);
        ack_at(b + 14);
        sample(b + 37);
        check("s3_fault", fault, 1);
        check("s3_inhibit", coin_inhibit, 1);
        check("s3_busy", busy, 0);
        goto(b + 38);
        vend_r = 1'b1;
        goto(b + 39);
        vend_r = 1'b0;
        sample(b + 39);
        check("s3_overrun_set", overrun, 1);
        goto(b + 40);
        fault_clr = 1'b1;
        goto(b + 41);
        fault_clr = 1'b0;
        sample(b + 41);
        check("s3_fault_clr", fault, 0);
        check("s3_overrun_clr", overrun, 0);
        check("s3_inhibit_clr", coin_inhibit, 0);
        goto(b + 44);

        // 4: second vend during latch -> overrun, first vend unaffected.
        b = cyc + 3;
        exp_pulse(0, b + 1, 4);
        exp_pulse(3, b + 7, 1);
        vend(b, 0, 0, 0);
        vend(b + 2, 1, 0, 0);
        sample(b + 3);
        check("s4_overrun", overrun, 1);
        sample(b + 8);
        check("s4_overrun_hold", overrun, 1);
        check("s4_busy_end", busy, 0);
        goto(b + 12);

        // 5: async reset during nickel eject, then a clean vend.
        b = cyc + 3;
        exp_pulse(0, b + 1, 4);
        exp_pulse(1, b + 7, 1);
        vend(b, 1, 0, 0);
        goto(b + 8);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_nickel_async", nickel_eject, 0);
        check("s5_busy_async", busy, 0);
        check("s5_inhibit_async", coin_inhibit, 0);
        check("s5_overrun_async", overrun, 0);
        goto(b + 10);
        rst_n = 1'b1;
        b = cyc + 2;
        exp_pulse(0, b + 1, 4);
        exp_pulse(3, b + 7, 1);
        vend(b, 0, 0, 0);
        sample(b + 8);
        check("s5_busy_end", busy, 0);
        goto(b + 12);

        check("events_left", 8'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
